fpu_muldiv_sequencer: RTL and testbench

FPU_MULDIV_SEQUENCER -- requirements
Module: fpu_muldiv_sequencer

---
 rtl/fpu_muldiv_sequencer.sv | 132 +++++++++++++
 tb/tb_fpu_muldiv_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_muldiv_sequencer.sv
// Sequencer for a half-precision multiply/divide unit: request handshake, unit launch, response hold.
// Define MULDIV_TIMEOUT_EN to compile in the WAIT-state abort counter (limit TIMEOUT_CYCLES).
module fpu_muldiv_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  input  logic        req_div,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_ofuf,
  output logic        rsp_timeout,
  output logic [15:0] u_x,
  output logic [15:0] u_y,
  output logic        u_mulDiv,
  output logic        u_reset,
  input  logic        u_done,
  input  logic [15:0] u_result,
  input  logic [1:0]  u_ofuf,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state;
  logic   launch_reg;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fpu_muldiv_sequencer: TIMEOUT_CYCLES must be in 2..255");
  end

  // The unit is held in reset for the whole of a global reset as well as the LAUNCH cycle.
  assign u_reset = launch_reg | reset;

`ifdef MULDIV_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;
  logic       timeout_reg;

  assign rsp_timeout = timeout_reg;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 16'h0000;
      rsp_ofuf   <= 2'b00;
      launch_reg <= 1'b0;
      u_x        <= 16'h0000;
      u_y        <= 16'h0000;
      u_mulDiv   <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      wait_cnt    <= 8'd0;
      timeout_reg <= 1'b0;
`endif
    end else begin
      launch_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            u_x        <= req_x;
            u_y        <= req_y;
            u_mulDiv   <= req_div;
            launch_reg <= 1'b1;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_GUARD;
        // u_done here may still be the previous operation's; it is deliberately not looked at.
        S_GUARD: begin
`ifdef MULDIV_TIMEOUT_EN
          wait_cnt <= 8'd0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (u_done) begin
            rsp_result <= u_result;
            rsp_ofuf   <= u_ofuf;
            rsp_valid  <= 1'b1;
            state      <= S_HOLD;
`ifdef MULDIV_TIMEOUT_EN
            timeout_reg <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == TIMEOUT_LIMIT) begin
              rsp_result  <= 16'h7E00;
              rsp_ofuf    <= 2'b00;
              timeout_reg <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= S_HOLD;
            end
`endif
          end
        end
        S_HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_muldiv_sequencer.sv
// Directed bench for fpu_muldiv_sequencer with a table-driven stand-in for the mul/div unit.
// Build with +define+MULDIV_TIMEOUT_EN to include the timeout scenario.
module tb_fpu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_x = 16'h0000;
  logic [15:0] req_y = 16'h0000;
  logic        req_div = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_ofuf;
  logic        rsp_timeout;
  logic [15:0] u_x;
  logic [15:0] u_y;
  logic        u_mulDiv;
  logic        u_reset;
  logic        u_done;
  logic [15:0] u_result;
  logic [1:0]  u_ofuf;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Unit stand-in controls: latency after reset, stall forever, and delayed reset response.
  int lat = 1;
  bit stall = 1'b0;
  bit stale_mode = 1'b0;

  always #5 clk = ~clk;

  fpu_muldiv_sequencer #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_div(req_div),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_ofuf(rsp_ofuf), .rsp_timeout(rsp_timeout),
    .u_x(u_x), .u_y(u_y), .u_mulDiv(u_mulDiv), .u_reset(u_reset),
    .u_done(u_done), .u_result(u_result), .u_ofuf(u_ofuf),
    .busy(busy)
  );

  // Known half-precision results: {result, ofuf}.
  function automatic logic [17:0] unit_model(input logic [15:0] x, input logic [15:0] y, input logic d);
    if (x == 16'h4F00 && y == 16'h0B80 && !d) return {16'h1E90, 2'b00};
    if (x == 16'hD98D && y == 16'h4F08 && !d) return {16'hECE0, 2'b00};
    if (x == 16'hD98D && y == 16'h4F08 && d)  return {16'hC650, 2'b00};
    if (x == 16'h118D && y == 16'hEF08 && d)  return {16'h8000, 2'b01};
    if (x == 16'h418D && y == 16'hB308 && d)  return {16'hCA50, 2'b00};
    return {16'hDEAD, 2'b11};
  endfunction

  logic [7:0] ucnt;
  logic       rst_d;
  always @(posedge clk) begin
    rst_d <= u_reset;
    if (stale_mode ? rst_d : u_reset) begin
      ucnt     <= 8'd0;
      u_done   <= 1'b0;
      u_result <= 16'h0000;
      u_ofuf   <= 2'b00;
    end else begin
      if (ucnt != 8'hFF) ucnt <= ucnt + 8'd1;
      if (!u_done && !stall && (int'(ucnt) + 1 >= lat)) begin
        u_done <= 1'b1;
        {u_result, u_ofuf} <= unit_model(u_x, u_y, u_mulDiv);
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic d, output bit ok);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    ok = req_ready;
    req_x = x;
    req_y = y;
    req_div = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit got, output int edges);
    edges = 0;
    while (!rsp_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    got = rsp_valid;
    $display("rsp x=%h y=%h div=%b -> result=%h ofuf=%b timeout=%b after %0d edges",
             u_x, u_y, u_mulDiv, rsp_result, rsp_ofuf, rsp_timeout, edges);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, busy, rsp_valid, rsp_result, rsp_ofuf, rsp_timeout, u_x, u_y, u_mulDiv, u_reset}
        !== {1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b busy=%b vld=%b res=%h ofuf=%b to=%b ux=%h uy=%h md=%b urst=%b want 1 0 0 0000 00 0 0000 0000 0 1",
               req_ready, busy, rsp_valid, rsp_result, rsp_ofuf, rsp_timeout, u_x, u_y, u_mulDiv, u_reset);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, busy, rsp_valid, u_reset} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_release: got rdy/busy/vld/urst=%b want 1000", {req_ready, busy, rsp_valid, u_reset});
    end
  endtask

  task automatic test_multiply();
    bit ok;
    int edges = 0;
    int urst = 0;
    lat = 1;
    issue(16'h4F00, 16'h0B80, 1'b0, ok);
    n_cmp++;
    if (!ok || {busy, req_ready, u_x, u_y, u_mulDiv} !== {1'b1, 1'b0, 16'h4F00, 16'h0B80, 1'b0}) begin
      n_bad++;
      $display("FAIL mul_launch: got ok=%b busy=%b rdy=%b ux=%h uy=%h md=%b want 1 1 0 4f00 0b80 0",
               ok, busy, req_ready, u_x, u_y, u_mulDiv);
    end
    if (u_reset) urst++;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (u_reset) urst++;
    end
    $display("rsp x=%h y=%h div=%b -> result=%h ofuf=%b after %0d edges", u_x, u_y, u_mulDiv, rsp_result, rsp_ofuf, edges);
    n_cmp++;
    if (edges !== 3) begin
      n_bad++;
      $display("FAIL mul_latency: got %0d edges want 3", edges);
    end
    n_cmp++;
    if (urst !== 1) begin
      n_bad++;
      $display("FAIL mul_ureset_pulse: got %0d cycles want 1", urst);
    end
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_ofuf, rsp_timeout} !== {1'b1, 16'h1E90, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL mul_result: got vld=%b res=%h ofuf=%b to=%b want 1 1e90 00 0", rsp_valid, rsp_result, rsp_ofuf, rsp_timeout);
    end
    accept();
    n_cmp++;
    if ({rsp_valid, req_ready, busy, rsp_result} !== {1'b0, 1'b1, 1'b0, 16'h1E90}) begin
      n_bad++;
      $display("FAIL mul_accept: got vld=%b rdy=%b busy=%b res=%h want 0 1 0 1e90", rsp_valid, req_ready, busy, rsp_result);
    end
  endtask

  task automatic test_guard_stale();
    bit ok, got;
    int edges;
    stale_mode = 1'b1;
    lat = 2;
    issue(16'hD98D, 16'h4F08, 1'b0, ok);
    wait_rsp(got, edges);
    n_cmp++;
    if (!ok || !got || rsp_result !== 16'hECE0) begin
      n_bad++;
      $display("FAIL guard_stale: got ok=%b vld=%b res=%h want 1 1 ece0", ok, got, rsp_result);
    end
    accept();
    stale_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, got1, got2;
    int e1, e2;
    logic [15:0] r1, r2;
    lat = 3;
    rsp_ready = 1'b1;
    issue(16'hD98D, 16'h4F08, 1'b0, ok1);
    wait_rsp(got1, e1);
    r1 = rsp_result;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_single_rsp: got vld=%b want 0", rsp_valid);
    end
    issue(16'hD98D, 16'h4F08, 1'b1, ok2);
    wait_rsp(got2, e2);
    r2 = rsp_result;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_cmp++;
    if (!ok1 || !got1 || r1 !== 16'hECE0) begin
      n_bad++;
      $display("FAIL b2b_mul: got ok=%b vld=%b res=%h want 1 1 ece0", ok1, got1, r1);
    end
    n_cmp++;
    if (!ok2 || !got2 || r2 !== 16'hC650) begin
      n_bad++;
      $display("FAIL b2b_div: got ok=%b vld=%b res=%h want 1 1 c650", ok2, got2, r2);
    end
  endtask

  task automatic test_flags();
    bit ok, got;
    int edges;
    lat = 2;
    issue(16'h118D, 16'hEF08, 1'b1, ok);
    wait_rsp(got, edges);
    n_cmp++;
    if (!ok || !got || rsp_ofuf !== 2'b01) begin
      n_bad++;
      $display("FAIL div_underflow: got ok=%b vld=%b ofuf=%b want 1 1 01", ok, got, rsp_ofuf);
    end
    accept();
    issue(16'h418D, 16'hB308, 1'b1, ok);
    wait_rsp(got, edges);
    n_cmp++;
    if (!ok || !got || {rsp_result, rsp_ofuf} !== {16'hCA50, 2'b00}) begin
      n_bad++;
      $display("FAIL div_not_sticky: got ok=%b vld=%b res=%h ofuf=%b want 1 1 ca50 00", ok, got, rsp_result, rsp_ofuf);
    end
    accept();
  endtask

  task automatic test_hold_stall();
    bit ok, got;
    int edges;
    lat = 1;
    issue(16'h4F00, 16'h0B80, 1'b0, ok);
    wait_rsp(got, edges);
    req_x = 16'hD98D;
    req_y = 16'h4F08;
    req_div = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_result, rsp_ofuf, req_ready, u_reset, u_x} !== {1'b1, 16'h1E90, 2'b00, 1'b0, 1'b0, 16'h4F00}) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: got vld=%b res=%h ofuf=%b rdy=%b urst=%b ux=%h want 1 1e90 00 0 0 4f00",
                 i, rsp_valid, rsp_result, rsp_ofuf, req_ready, u_reset, u_x);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    n_cmp++;
    if ({rsp_valid, busy, req_ready, u_reset, u_x} !== {1'b0, 1'b0, 1'b1, 1'b0, 16'h4F00}) begin
      n_bad++;
      $display("FAIL hold_release_no_launch: got vld=%b busy=%b rdy=%b urst=%b ux=%h want 0 0 1 0 4f00",
               rsp_valid, busy, req_ready, u_reset, u_x);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_idle_after: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_midop();
    bit ok, got;
    int edges;
    lat = 8;
    issue(16'h4F00, 16'h0B80, 1'b0, ok);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({rsp_valid, busy, req_ready, u_reset, u_x, u_y, u_mulDiv, rsp_result, rsp_ofuf, rsp_timeout}
        !== {1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL midop_reset: got vld=%b busy=%b rdy=%b urst=%b ux=%h uy=%h md=%b res=%h ofuf=%b to=%b",
               rsp_valid, busy, req_ready, u_reset, u_x, u_y, u_mulDiv, rsp_result, rsp_ofuf, rsp_timeout);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL midop_no_rsp: got vld=%b busy=%b want 0 0", rsp_valid, busy);
    end
    lat = 1;
    issue(16'hD98D, 16'h4F08, 1'b1, ok);
    wait_rsp(got, edges);
    n_cmp++;
    if (!ok || !got || rsp_result !== 16'hC650) begin
      n_bad++;
      $display("FAIL midop_recover: got ok=%b vld=%b res=%h want 1 1 c650", ok, got, rsp_result);
    end
    accept();
  endtask

`ifdef MULDIV_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, got;
    int edges;
    stall = 1'b1;
    issue(16'h418D, 16'hB308, 1'b1, ok);
    wait_rsp(got, edges);
    n_cmp++;
    if (!ok || !got || edges !== 12) begin
      n_bad++;
      $display("FAIL timeout_latency: got ok=%b vld=%b edges=%0d want 1 1 12", ok, got, edges);
    end
    n_cmp++;
    if ({rsp_result, rsp_ofuf, rsp_timeout} !== {16'h7E00, 2'b00, 1'b1}) begin
      n_bad++;
      $display("FAIL timeout_result: got res=%h ofuf=%b to=%b want 7e00 00 1", rsp_result, rsp_ofuf, rsp_timeout);
    end
    accept();
    stall = 1'b0;
    issue(16'h4F00, 16'h0B80, 1'b0, ok);
    wait_rsp(got, edges);
    n_cmp++;
    if (!got || {rsp_result, rsp_timeout} !== {16'h1E90, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_cleared: got vld=%b res=%h to=%b want 1 1e90 0", got, rsp_result, rsp_timeout);
    end
    accept();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multiply();
    test_guard_stale();
    test_back_to_back();
    test_flags();
    test_hold_stall();
    test_reset_midop();
`ifdef MULDIV_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
